// File: rtl/axi_wb_rdwr_arbiter.sv
// Shares one pipelined Wishbone master port between a read-only and a write-only
// bridge: round-robin grant per bus cycle, outstanding-request tracking, hang abort.
module axi_wb_rdwr_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int LGFIFO           = 4,
    parameter int LGTIMEOUT        = 10
) (
    input  logic                            i_axi_clk,
    input  logic                            i_axi_reset,
    input  logic                            i_rd_cyc,
    input  logic                            i_rd_stb,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     i_rd_addr,
    output logic                            o_rd_ack,
    output logic                            o_rd_stall,
    output logic                            o_rd_err,
    output logic [C_AXI_DATA_WIDTH-1:0]     o_rd_data,
    input  logic                            i_wr_cyc,
    input  logic                            i_wr_stb,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     i_wr_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0]     i_wr_data,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   i_wr_sel,
    output logic                            o_wr_ack,
    output logic                            o_wr_stall,
    output logic                            o_wr_err,
    output logic                            o_wb_cyc,
    output logic                            o_wb_stb,
    output logic                            o_wb_we,
    output logic [C_AXI_ADDR_WIDTH-1:0]     o_wb_addr,
    output logic [C_AXI_DATA_WIDTH-1:0]     o_wb_data,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   o_wb_sel,
    input  logic                            i_wb_ack,
    input  logic                            i_wb_stall,
    input  logic                            i_wb_err,
    input  logic [C_AXI_DATA_WIDTH-1:0]     i_wb_data
);

    localparam int CW = LGFIFO + 1;
    localparam logic [CW-1:0]        FULL_CNT = CW'(1 << LGFIFO);
    localparam logic [LGTIMEOUT-1:0] TMO_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, RD, WR, ABORT} state_t;

    state_t                 state, state_next;
    logic                   lsb, lsb_next;
    logic [CW-1:0]          outs;
    logic [LGTIMEOUT-1:0]   tmo;
    logic                   abort_wr, abort_err;

    logic rd_own, wr_own, busy, own_cyc, own_stb, other_cyc, abort_cyc;
    logic cnt_full, own_stall, accept, ack_dec, tmo_inc, tmo_hit, abort_pulse;

    assign rd_own    = (state == RD);
    assign wr_own    = (state == WR);
    assign busy      = rd_own | wr_own;
    assign own_cyc   = rd_own ? i_rd_cyc : (wr_own ? i_wr_cyc : 1'b0);
    assign own_stb   = rd_own ? i_rd_stb : (wr_own ? i_wr_stb : 1'b0);
    assign other_cyc = rd_own ? i_wr_cyc : i_rd_cyc;
    assign abort_cyc = abort_wr ? i_wr_cyc : i_rd_cyc;

    assign cnt_full  = (outs == FULL_CNT);
    assign own_stall = i_wb_stall | cnt_full;
    assign accept    = o_wb_stb & ~own_stall;
    assign ack_dec   = busy & i_wb_ack & (outs != '0);
    assign tmo_inc   = busy & (outs != '0) & ~i_wb_ack;
    // Abort on the edge where the timer would land on all-ones.
    assign tmo_hit   = tmo_inc & ~accept & (tmo == TMO_LAST);

    assign o_wb_cyc  = own_cyc;
    assign o_wb_stb  = own_cyc & own_stb & ~cnt_full;
    assign o_wb_we   = wr_own;
    assign o_wb_addr = wr_own ? i_wr_addr : i_rd_addr;
    assign o_wb_data = wr_own ? i_wr_data : '0;
    assign o_wb_sel  = wr_own ? i_wr_sel  : '1;

    assign abort_pulse = (state == ABORT) & abort_err;
    assign o_rd_stall  = ~rd_own | own_stall;
    assign o_wr_stall  = ~wr_own | own_stall;
    assign o_rd_ack    = rd_own & i_wb_ack;
    assign o_wr_ack    = wr_own & i_wb_ack;
    assign o_rd_err    = (rd_own & i_wb_err) | (abort_pulse & ~abort_wr);
    assign o_wr_err    = (wr_own & i_wb_err) | (abort_pulse &  abort_wr);
    assign o_rd_data   = i_wb_data;

    always_comb begin
        state_next = state;
        lsb_next   = lsb;
        case (state)
            IDLE: begin
                if (i_rd_cyc && i_wr_cyc)
                    state_next = lsb ? RD : WR;
                else if (i_rd_cyc)
                    state_next = RD;
                else if (i_wr_cyc)
                    state_next = WR;
            end
            RD, WR: begin
                if (i_wb_err || tmo_hit) begin
                    state_next = ABORT;
                end else if (!own_cyc) begin
                    lsb_next = wr_own;
                    if (other_cyc)
                        state_next = rd_own ? WR : RD;
                    else
                        state_next = IDLE;
                end
            end
            ABORT: begin
                if (!abort_cyc)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_reset) begin
        if (i_axi_reset) begin
            state     <= IDLE;
            lsb       <= 1'b1;
            abort_wr  <= 1'b0;
            abort_err <= 1'b0;
        end else begin
            state     <= state_next;
            lsb       <= lsb_next;
            abort_err <= 1'b0;
            // A bus error was already forwarded, so only a timeout raises the entry pulse.
            if (state_next == ABORT && state != ABORT) begin
                abort_wr  <= wr_own;
                abort_err <= ~i_wb_err;
            end
        end
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_reset) begin
        if (i_axi_reset) begin
            outs <= '0;
            tmo  <= '0;
        end else begin
            if (state_next != state)
                outs <= '0;
            else if (accept && !ack_dec)
                outs <= outs + CW'(1);
            else if (!accept && ack_dec)
                outs <= outs - CW'(1);

            if (state_next != state || !busy || i_wb_ack || accept)
                tmo <= '0;
            else if (tmo_inc)
                tmo <= tmo + LGTIMEOUT'(1);
        end
    end

endmodule

// File: tb/tb_axi_wb_rdwr_arbiter.sv
// Self-checking bench for axi_wb_rdwr_arbiter: scoreboarded read/write traffic
// through a latency-one slave model plus directed grant, full, timeout and error cases.
module tb_axi_wb_rdwr_arbiter;

    typedef struct packed {
        logic        we;
        logic [27:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wb_item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rd_cyc = 0, rd_stb = 0;
    logic [27:0] rd_addr = '0;
    logic wr_cyc = 0, wr_stb = 0;
    logic [27:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_sel = 4'hF;
    logic wb_ack = 0, wb_stall = 0, wb_err = 0;
    logic [31:0] wb_data = '0;
    logic o_rd_ack, o_rd_stall, o_rd_err, o_wr_ack, o_wr_stall, o_wr_err;
    logic o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_rd_data, o_wb_data;
    logic [27:0] o_wb_addr;
    logic [3:0]  o_wb_sel;

    int total = 0, bad = 0;
    int rd_acks = 0, wr_acks = 0;
    bit rd_acc_now = 0, wr_acc_now = 0;
    bit ack_en = 1, inject_ack = 0, inject_err = 0;
    logic [31:0] rd_exp[$];
    wb_item_t    wr_exp[$];
    wb_item_t    slave_q[$];
    wb_item_t    cur = '0;

    axi_wb_rdwr_arbiter #(
        .C_AXI_ADDR_WIDTH(28), .C_AXI_DATA_WIDTH(32), .LGFIFO(2), .LGTIMEOUT(4)
    ) dut (
        .i_axi_clk(clk), .i_axi_reset(rst),
        .i_rd_cyc(rd_cyc), .i_rd_stb(rd_stb), .i_rd_addr(rd_addr),
        .o_rd_ack(o_rd_ack), .o_rd_stall(o_rd_stall), .o_rd_err(o_rd_err), .o_rd_data(o_rd_data),
        .i_wr_cyc(wr_cyc), .i_wr_stb(wr_stb), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_sel(wr_sel),
        .o_wr_ack(o_wr_ack), .o_wr_stall(o_wr_stall), .o_wr_err(o_wr_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fdata(input logic [27:0] a);
        return {4'h5, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then the slave answers just after the rising edge.
    task automatic step();
        wb_item_t e;
        logic [31:0] d;
        @(negedge clk);
        if (o_rd_ack) begin
            rd_acks++;
            checkOutput("rd_ack_pending", 64'(rd_exp.size() != 0), 64'd1);
            if (rd_exp.size() != 0) begin
                d = rd_exp.pop_front();
                checkOutput("rd_data", 64'(o_rd_data), 64'(d));
                checkOutput("rd_we", 64'(cur.we), 64'd0);
            end
        end
        if (o_wr_ack) begin
            wr_acks++;
            checkOutput("wr_ack_pending", 64'(wr_exp.size() != 0), 64'd1);
            if (wr_exp.size() != 0) begin
                e = wr_exp.pop_front();
                checkOutput("wr_we", 64'(cur.we), 64'd1);
                checkOutput("wr_addr", 64'(cur.addr), 64'(e.addr));
                checkOutput("wr_data", 64'(cur.data), 64'(e.data));
                checkOutput("wr_sel", 64'(cur.sel), 64'(e.sel));
            end
        end
        rd_acc_now = rd_cyc && rd_stb && !o_rd_stall;
        wr_acc_now = wr_cyc && wr_stb && !o_wr_stall;
        if (rd_acc_now) rd_exp.push_back(fdata(rd_addr));
        if (wr_acc_now) wr_exp.push_back('{1'b1, wr_addr, wr_data, wr_sel});
        if (o_wb_stb && !wb_stall) slave_q.push_back('{o_wb_we, o_wb_addr, o_wb_data, o_wb_sel});
        @(posedge clk);
        #1;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        if (inject_err) begin
            wb_err = 1'b1;
            inject_err = 0;
        end else if ((ack_en || inject_ack) && slave_q.size() != 0) begin
            cur = slave_q.pop_front();
            wb_ack = 1'b1;
            wb_data = fdata(cur.addr);
        end
        inject_ack = 0;
        #1;
    endtask

    // Issue n strobes from one master and wait for all n acks (cycle budget bounded).
    task automatic applyStimulus(input bit wr, input int n, input logic [27:0] base);
        int sent, acks0, guard;
        sent = 0;
        guard = 0;
        acks0 = wr ? wr_acks : rd_acks;
        while ((sent < n || (wr ? wr_acks : rd_acks) - acks0 < n) && guard < 100) begin
            if (wr) begin
                wr_stb  = (sent < n);
                wr_addr = base + 28'(sent);
                wr_data = 32'hA500_0000 + 32'(sent) + 32'(base);
            end else begin
                rd_stb  = (sent < n);
                rd_addr = base + 28'(sent);
            end
            step();
            if (wr ? wr_acc_now : rd_acc_now) sent++;
            guard++;
        end
        rd_stb = 0;
        wr_stb = 0;
        checkOutput(wr ? "wr_burst_done" : "rd_burst_done", 64'(guard < 100), 64'd1);
    endtask

    task automatic drainReads();
        int guard;
        guard = 0;
        ack_en = 1;
        while (rd_exp.size() != 0 && guard < 50) begin
            step();
            guard++;
        end
        checkOutput("rd_drain", 64'(rd_exp.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sent;
        bit own_wr;

        // Reset values
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_wb_cyc", 64'(o_wb_cyc), 64'd0);
        checkOutput("rst_wb_stb", 64'(o_wb_stb), 64'd0);
        checkOutput("rst_wb_we", 64'(o_wb_we), 64'd0);
        checkOutput("rst_rd_stall", 64'(o_rd_stall), 64'd1);
        checkOutput("rst_wr_stall", 64'(o_wr_stall), 64'd1);
        checkOutput("rst_wb_sel", 64'(o_wb_sel), 64'hF);
        checkOutput("rst_errs", 64'({o_rd_ack, o_wr_ack, o_rd_err, o_wr_err}), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Simultaneous request after reset: read wins, then write takes over without idle
        $display("[TB] simultaneous request");
        wr_sel = 4'hC;
        rd_cyc = 1;
        wr_cyc = 1;
        step();
        checkOutput("sim_rd_stall", 64'(o_rd_stall), 64'd0);
        checkOutput("sim_wr_stall", 64'(o_wr_stall), 64'd1);
        checkOutput("sim_wb_cyc", 64'(o_wb_cyc), 64'd1);
        checkOutput("sim_wb_we", 64'(o_wb_we), 64'd0);
        applyStimulus(1'b0, 3, 28'h0010);
        rd_cyc = 0;
        step();
        checkOutput("hand_wr_stall", 64'(o_wr_stall), 64'd0);
        checkOutput("hand_rd_stall", 64'(o_rd_stall), 64'd1);
        checkOutput("hand_wb_we", 64'(o_wb_we), 64'd1);
        checkOutput("hand_wb_sel", 64'(o_wb_sel), 64'hC);
        applyStimulus(1'b1, 2, 28'h0020);
        wr_cyc = 0;
        step();

        // Round robin with both masters continuously requesting
        $display("[TB] round robin");
        wr_sel = 4'h3;
        rd_cyc = 1;
        wr_cyc = 1;
        step();
        for (int g = 0; g < 4; g++) begin
            own_wr = (g % 2) == 1;
            checkOutput("rr_rd_stall", 64'(o_rd_stall), 64'(own_wr));
            checkOutput("rr_wr_stall", 64'(o_wr_stall), 64'(!own_wr));
            applyStimulus(own_wr, 4, 28'(256 * (g + 1)));
            if (own_wr) wr_cyc = 0; else rd_cyc = 0;
            step();
            if (own_wr) wr_cyc = 1; else rd_cyc = 1;
        end
        rd_cyc = 0;
        wr_cyc = 0;
        step();

        // Outstanding limit of four with the slave holding acks
        $display("[TB] outstanding full");
        ack_en = 0;
        rd_cyc = 1;
        step();
        rd_stb = 1;
        sent = 0;
        for (int i = 0; i < 8 && sent < 4; i++) begin
            rd_addr = 28'h0400 + 28'(sent);
            step();
            if (rd_acc_now) sent++;
        end
        checkOutput("full_sent", 64'(sent), 64'd4);
        rd_addr = 28'h0404;
        #1;
        checkOutput("full_rd_stall", 64'(o_rd_stall), 64'd1);
        checkOutput("full_wb_stb", 64'(o_wb_stb), 64'd0);
        inject_ack = 1;
        step();
        checkOutput("full_ack_cycle_stall", 64'(o_rd_stall), 64'd1);
        step();
        checkOutput("full_after_ack_stall", 64'(o_rd_stall), 64'd0);
        checkOutput("full_after_ack_stb", 64'(o_wb_stb), 64'd1);
        step();
        checkOutput("full_refill_accept", 64'(rd_acc_now), 64'd1);
        checkOutput("full_refill_stall", 64'(o_rd_stall), 64'd1);
        rd_stb = 0;
        drainReads();
        rd_cyc = 0;
        step();

        // Timeout: one accepted write that the slave never acknowledges
        $display("[TB] timeout");
        ack_en = 0;
        wr_cyc = 1;
        step();
        wr_stb = 1;
        wr_addr = 28'h0500;
        wr_data = 32'hDEAD_BEEF;
        step();
        checkOutput("tmo_accept", 64'(wr_acc_now), 64'd1);
        wr_stb = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checkOutput("tmo_wr_err", 64'(o_wr_err), 64'(k == 15));
            if (k >= 15) checkOutput("tmo_wb_cyc", 64'(o_wb_cyc), 64'd0);
        end
        wr_cyc = 0;
        step();
        inject_ack = 1;
        step();
        checkOutput("late_ack_wr", 64'(o_wr_ack), 64'd0);
        checkOutput("late_ack_rd", 64'(o_rd_ack), 64'd0);
        wr_exp.delete();
        slave_q.delete();

        // Bus error during a read burst while a write waits
        $display("[TB] bus error");
        ack_en = 1;
        rd_cyc = 1;
        step();
        wr_cyc = 1;
        applyStimulus(1'b0, 2, 28'h0600);
        inject_err = 1;
        step();
        checkOutput("err_rd_err", 64'(o_rd_err), 64'd1);
        checkOutput("err_wr_err", 64'(o_wr_err), 64'd0);
        checkOutput("err_wb_cyc", 64'(o_wb_cyc), 64'd1);
        step();
        checkOutput("abort_wb_cyc", 64'(o_wb_cyc), 64'd0);
        checkOutput("abort_rd_err", 64'(o_rd_err), 64'd0);
        checkOutput("abort_wr_stall", 64'(o_wr_stall), 64'd1);
        step();
        checkOutput("abort_hold_wr_stall", 64'(o_wr_stall), 64'd1);
        rd_cyc = 0;
        step();
        checkOutput("idle_wr_stall", 64'(o_wr_stall), 64'd1);
        step();
        checkOutput("err_wr_grant", 64'(o_wr_stall), 64'd0);
        checkOutput("err_wr_we", 64'(o_wb_we), 64'd1);
        wr_cyc = 0;
        step();

        // Asynchronous reset in the middle of a read cycle
        $display("[TB] reset mid-cycle");
        ack_en = 0;
        rd_cyc = 1;
        step();
        rd_stb = 1;
        sent = 0;
        for (int i = 0; i < 6 && sent < 3; i++) begin
            rd_addr = 28'h0700 + 28'(sent);
            step();
            if (rd_acc_now) sent++;
        end
        rd_stb = 0;
        checkOutput("mid_sent", 64'(sent), 64'd3);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_wb_cyc", 64'(o_wb_cyc), 64'd0);
        checkOutput("mid_rst_rd_stall", 64'(o_rd_stall), 64'd1);
        checkOutput("mid_rst_wb_sel", 64'(o_wb_sel), 64'hF);
        rd_cyc = 0;
        step();
        step();
        rst = 1'b0;
        rd_exp.delete();
        slave_q.delete();
        rd_cyc = 1;
        step();
        checkOutput("post_rst_grant", 64'(o_rd_stall), 64'd0);
        rd_stb = 1;
        sent = 0;
        for (int i = 0; i < 8 && sent < 4; i++) begin
            rd_addr = 28'h0800 + 28'(sent);
            step();
            if (rd_acc_now) sent++;
        end
        rd_stb = 0;
        checkOutput("post_rst_sent", 64'(sent), 64'd4);
        checkOutput("post_rst_full", 64'(o_rd_stall), 64'd1);
        drainReads();
        rd_cyc = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
